// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: runtime parity (none/even/odd), 1 or 2 stop bits, glitch/break aware.
// Latency: word appears on o_rx_valid the cycle after the final stop-bit sample stick.
// Backpressure: one-word holding register; a frame completing while it is still full is dropped and flagged on o_overrun.
module uart_rx_cfg #(
  parameter int SIZE_DATA   = 8,
  parameter int OVER_SAMPLE = 16,
  parameter int MID_SAMPLE  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stick,
  input  logic                 i_rx_en,
  input  logic                 i_rx_serial,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_two_stop,
  input  logic                 i_rx_ready,
  output logic [SIZE_DATA-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVER_SAMPLE);
  localparam int BW = $clog2(SIZE_DATA);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVER_SAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(MID_SAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SIZE_DATA - 1);
  localparam logic [1:0]    PAR_EVEN  = 2'b01;
  localparam logic [1:0]    PAR_ODD   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta, rx_s;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [SIZE_DATA-1:0]   shreg_q, shreg_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [1:0]             mode_q, mode_d;
  logic                   two_stop_q, two_stop_d;
  logic                   stop2_q, stop2_d;
  logic                   complete;
  logic                   tick_last;
  logic                   par_en;

  assign tick_last = i_stick && (tick_q == TICK_LAST);
  assign par_en    = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
  assign o_busy    = (state_q != IDLE);

  // Two-flop synchroniser for the asynchronous line; idles high so reset never fakes a start bit
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial;
      rx_s    <= rx_meta;
    end
  end

  // Frame state register and per-frame working state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      mode_q     <= 2'b00;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      mode_q     <= mode_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
    end
  end

  // Next-state logic: counters only move on stick cycles; framing options frozen at start detection
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    mode_d     = mode_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    complete   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rx_en && !rx_s) begin
          state_d    = START;
          tick_d     = '0;
          mode_d     = i_parity_mode;
          two_stop_d = i_two_stop;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          stop2_d    = 1'b0;
        end
      end
      START: begin
        if (i_stick) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
            end else begin
              // Line bounced back high before mid-bit: treat as noise
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_last) begin
          tick_d  = '0;
          shreg_d = {rx_s, shreg_q[SIZE_DATA-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = par_en ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else if (i_stick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      PARITY: begin
        if (tick_last) begin
          tick_d  = '0;
          perr_d  = ((^shreg_q) ^ rx_s) != (mode_q == PAR_ODD);
          state_d = STOP;
        end else if (i_stick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (tick_last) begin
          tick_d = '0;
          ferr_d = ferr_q | ~rx_s;
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            complete = 1'b1;
            // A low line with a bad stop bit is a break: park until it releases
            state_d  = (ferr_d && !rx_s) ? BREAK : IDLE;
          end
        end else if (i_stick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output holding register: load on completion when empty or draining, otherwise drop and flag overrun
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (complete) begin
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_data    <= shreg_q;
          o_parity_err <= perr_q;
          o_frame_err  <= ferr_d;
          o_rx_valid   <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are driven bit by bit, expected words queued, monitor pops on transfer.
// Latency: checks are independent of exact delivery cycle; only order and content of words matter.
// Backpressure: exercised via rx_ready low for the overrun sequence.
module tb_uart_rx_cfg;

  // Short stick period keeps every frame to a few hundred clocks
  localparam int STICK_DIV = 4;
  localparam int OS        = 16;
  localparam int BIT_CLKS  = OS * STICK_DIV;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       stick;
  logic       rx_en;
  logic       rx;
  logic [1:0] pmode;
  logic       two_stop;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   vectors;
  int   miscompares;
  int   wcount;
  int   ovr_cnt;
  int   vrun;
  int   last_run;
  int   sdiv;
  int   npush;
  int   w0;
  exp_t mon_e;
  exp_t sb[$];

  uart_rx_cfg #(.SIZE_DATA(8), .OVER_SAMPLE(OS), .MID_SAMPLE(OS/2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stick      (stick),
    .i_rx_en      (rx_en),
    .i_rx_serial  (rx),
    .i_parity_mode(pmode),
    .i_two_stop   (two_stop),
    .i_rx_ready   (rx_ready),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err),
    .o_overrun    (overrun),
    .o_busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    stick = 1'b0;
    sdiv  = 0;
    forever begin
      @(negedge clk);
      sdiv  = (sdiv == STICK_DIV - 1) ? 0 : sdiv + 1;
      stick = (sdiv == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic f);
    sb.push_back({d, p, f});
    npush++;
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic s1, input logic two, input logic s2);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (has_par) bit_time(pbit);
    bit_time(s1);
    if (two) bit_time(s2);
    idle_bits(2);
  endtask

  // Monitor: pop the scoreboard on every transfer, track overrun pulses and valid run length
  initial begin
    forever begin
      @(negedge clk);
      if (overrun) ovr_cnt++;
      if (rx_valid) vrun++;
      else if (vrun != 0) begin
        last_run = vrun;
        vrun     = 0;
      end
      if (rx_valid && rx_ready) begin
        wcount++;
        vectors++;
        assert (sb.size() > 0) else begin
          miscompares++;
          $error("FAIL unexpected_word: observed %0h expected none", rx_data);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          vectors++;
          assert ({rx_data, parity_err, frame_err} === mon_e) else begin
            miscompares++;
            $error("FAIL word: observed d=%0h p=%0b f=%0b expected d=%0h p=%0b f=%0b",
                   rx_data, parity_err, frame_err, mon_e.d, mon_e.p, mon_e.f);
          end
        end
      end
    end
  end

  initial begin
    vectors = 0; miscompares = 0; wcount = 0; ovr_cnt = 0;
    vrun = 0; last_run = 0; npush = 0;
    rst_n = 1'b0; rx = 1'b1; rx_en = 1'b1; pmode = 2'b00;
    two_stop = 1'b0; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {rx_data, rx_valid, parity_err, frame_err, overrun, busy}, 32'h0);
    rst_n = 1'b1;
    idle_bits(1);

    // Plain 8N1
    push(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("n81_busy_after_stop", 32'(busy), 32'd0);
    check("n81_valid_one_cycle", 32'(last_run), 32'd1);
    check("n81_words", 32'(wcount), 32'd1);

    // Even and odd parity, good and bad
    pmode = 2'b01;
    push(8'hA5, 1'b0, 1'b0); send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    push(8'hA5, 1'b1, 1'b0); send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    pmode = 2'b10;
    push(8'h01, 1'b0, 1'b0); send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    push(8'h01, 1'b1, 1'b0); send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // Mode 11 behaves as no parity
    pmode = 2'b11;
    push(8'h5A, 1'b0, 1'b0); send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("parity_words", 32'(wcount), 32'd6);

    // Two stop bits: good, then bad second stop
    pmode = 2'b00; two_stop = 1'b1;
    push(8'hC3, 1'b0, 1'b0); send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    push(8'h3C, 1'b0, 1'b1); send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("two_stop_busy", 32'(busy), 32'd0);
    two_stop = 1'b0;

    // Break: 0x00 data then line held low for 20 bit times
    w0 = wcount;
    push(8'h00, 1'b0, 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(1'b0);
    repeat (20 * BIT_CLKS) @(negedge clk);
    check("break_one_word", 32'(wcount - w0), 32'd1);
    check("break_busy_held", 32'(busy), 32'd1);
    idle_bits(2);
    check("break_released", 32'(busy), 32'd0);
    check("break_no_extra", 32'(wcount - w0), 32'd1);

    // Start-bit glitch of 4 sticks
    w0 = wcount;
    rx = 1'b0;
    repeat (4 * STICK_DIV) @(negedge clk);
    check("glitch_busy_during", 32'(busy), 32'd1);
    idle_bits(2);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_no_word", 32'(wcount - w0), 32'd0);
    push(8'h55, 1'b0, 1'b0); send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Receiver disabled: start bits ignored
    w0 = wcount;
    rx_en = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("disabled_no_word", 32'(wcount - w0), 32'd0);
    rx_en = 1'b1;

    // Overrun with consumer stalled
    check("ovr_none_before", 32'(ovr_cnt), 32'd0);
    rx_ready = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_data_held", 32'(rx_data), 32'h11);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_one_pulse", 32'(ovr_cnt), 32'd1);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    check("ovr_valid_drops", 32'(rx_valid), 32'd0);
    @(negedge clk);

    // Reset in the middle of a frame
    w0 = wcount;
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    rst_n = 1'b0; rx = 1'b1;
    @(posedge clk); #1;
    check("midreset_outputs", {rx_data, rx_valid, parity_err, frame_err, overrun, busy}, 32'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    push(8'h81, 1'b0, 1'b0); send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("midreset_one_word", 32'(wcount - w0), 32'd1);

    idle_bits(1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("total_words", 32'(wcount), 32'(npush));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
